// File: rtl/bram_port_arbiter_pkg.sv
// bram_port_arbiter_pkg
//   Shared constants and types for the BRAM port arbiter.
//   - DEF_ADDR_BITS / DEF_DATA_BITS : default geometry of a 2K x 8 block RAM port
//   - src_tag_e                     : source of the read whose data appears on ram_do
package bram_port_arbiter_pkg;

    localparam int unsigned DEF_ADDR_BITS = 11;
    localparam int unsigned DEF_DATA_BITS = 8;

    typedef enum logic [1:0] {
        TAG_NONE    = 2'd0,
        TAG_VID     = 2'd1,
        TAG_HOST_RD = 2'd2
    } src_tag_e;

endpackage

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
//   Shares one port of a dual-port block RAM between a read-only video fetch
//   path (fixed priority) and a read/write host path. A starvation counter
//   forces a host grant after STARVE_MAX consecutive denied host cycles.
//   Ports:
//     clock, reset             : system clock, synchronous active-high reset
//     vid_req/vid_addr         : video read request and address
//     vid_gnt                  : video access taken this cycle
//     vid_valid/vid_data       : read data for the video access granted last cycle
//     host_req/host_we/host_addr/host_wdata : host request
//     host_gnt                 : host access taken this cycle
//     host_rvalid/host_rdata   : read data for the host read granted last cycle
//     ram_en/ram_we/ram_addr/ram_di : BRAM port drive
//     ram_do                   : BRAM registered read data
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_BITS  = DEF_ADDR_BITS,
    parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                 clock,
    input  logic                 reset,

    input  logic                 vid_req,
    input  logic [ADDR_BITS-1:0] vid_addr,
    output logic                 vid_gnt,
    output logic                 vid_valid,
    output logic [DATA_BITS-1:0] vid_data,

    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_BITS-1:0] host_addr,
    input  logic [DATA_BITS-1:0] host_wdata,
    output logic                 host_gnt,
    output logic                 host_rvalid,
    output logic [DATA_BITS-1:0] host_rdata,

    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [DATA_BITS-1:0] ram_di,
    input  logic [DATA_BITS-1:0] ram_do
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;
    src_tag_e   tag;
    logic       vid_win;
    logic       host_win;

    // Video wins ties unless the host has waited STARVE_MAX cycles.
    always_comb begin
        vid_win  = 1'b0;
        host_win = 1'b0;
        if (!reset) begin
            host_win = host_req && (!vid_req || starve_cnt == STARVE_LIM);
            vid_win  = vid_req && !host_win;
        end
    end

    always_comb begin
        vid_gnt  = vid_win;
        host_gnt = host_win;
        ram_en   = vid_win | host_win;
        ram_we   = host_win & host_we;
        ram_addr = '0;
        ram_di   = '0;
        if (host_win) begin
            ram_addr = host_addr;
            ram_di   = host_wdata;
        end else if (vid_win) begin
            ram_addr = vid_addr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
            tag        <= TAG_NONE;
        end else begin
            if (!host_req || host_win)
                starve_cnt <= '0;
            else if (starve_cnt != STARVE_LIM)
                starve_cnt <= starve_cnt + 4'd1;

            if (vid_win)
                tag <= TAG_VID;
            else if (host_win && !host_we)
                tag <= TAG_HOST_RD;
            else
                tag <= TAG_NONE;
        end
    end

    // Valids are masked by reset so a read granted just before reset
    // asserts never reports its data.
    assign vid_valid   = (tag == TAG_VID) && !reset;
    assign host_rvalid = (tag == TAG_HOST_RD) && !reset;
    assign vid_data    = ram_do;
    assign host_rdata  = ram_do;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter
//   Self-checking bench: directed scenarios plus randomized hold-until-grant
//   traffic, compared every cycle against a behavioural model of the arbiter
//   and a reference copy of the memory contents.
module tb_bram_port_arbiter;

    localparam int unsigned AW   = 11;
    localparam int unsigned DW   = 8;
    localparam int unsigned SMAX = 4;
    localparam int unsigned MEMN = 1 << AW;

    logic          clock;
    logic          reset;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_gnt;
    logic          vid_valid;
    logic [DW-1:0] vid_data;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di;
    logic [DW-1:0] ram_do;

    bram_port_arbiter #(
        .ADDR_BITS  (AW),
        .DATA_BITS  (DW),
        .STARVE_MAX (SMAX)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .vid_req     (vid_req),
        .vid_addr    (vid_addr),
        .vid_gnt     (vid_gnt),
        .vid_valid   (vid_valid),
        .vid_data    (vid_data),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_di      (ram_di),
        .ram_do      (ram_do)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Block RAM stand-in: write-first, one-cycle registered read.
    logic [DW-1:0] bram [MEMN];
    always @(posedge clock) begin
        if (ram_en) begin
            if (ram_we) begin
                bram[ram_addr] <= ram_di;
                ram_do         <= ram_di;
            end else begin
                ram_do <= bram[ram_addr];
            end
        end
    end

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [DW-1:0] ref_mem [MEMN];
    int            m_starve = 0;
    int            m_pend_src = 0;     // 0 none, 1 video, 2 host read
    logic [DW-1:0] m_pend_data = '0;
    bit            m_vg = 0;
    bit            m_hg = 0;

    always @(negedge clock) begin
        bit            hg, vg;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_di;
        hg = 0;
        vg = 0;
        if (!reset) begin
            if (host_req && (!vid_req || m_starve == SMAX)) hg = 1;
            else if (vid_req) vg = 1;
        end
        e_addr = hg ? host_addr : (vg ? vid_addr : '0);
        e_di   = hg ? host_wdata : '0;

        check_eq("vid_gnt",  vid_gnt,  vg);
        check_eq("host_gnt", host_gnt, hg);
        check_eq("ram_en",   ram_en,   vg | hg);
        check_eq("ram_we",   ram_we,   hg & host_we);
        check_eq("ram_addr", ram_addr, e_addr);
        check_eq("ram_di",   ram_di,   e_di);
        check_eq("vid_valid",   vid_valid,   m_pend_src == 1 && !reset);
        check_eq("host_rvalid", host_rvalid, m_pend_src == 2 && !reset);
        if (m_pend_src == 1 && !reset) check_eq("vid_data",   vid_data,   m_pend_data);
        if (m_pend_src == 2 && !reset) check_eq("host_rdata", host_rdata, m_pend_data);

        m_vg = vg;
        m_hg = hg;
        if (reset) begin
            m_starve   = 0;
            m_pend_src = 0;
        end else begin
            if (!host_req || hg) m_starve = 0;
            else if (m_starve < SMAX) m_starve = m_starve + 1;
            m_pend_src = 0;
            if (vg) begin
                m_pend_src  = 1;
                m_pend_data = ref_mem[vid_addr];
            end else if (hg && !host_we) begin
                m_pend_src  = 2;
                m_pend_data = ref_mem[host_addr];
            end else if (hg) begin
                ref_mem[host_addr] = host_wdata;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int         denied;
        bit         v_pend;
        bit         h_pend;
        logic [7:0] rb;

        for (int i = 0; i < int'(MEMN); i++) begin
            rb = 8'($urandom);
            bram[i]    = rb;
            ref_mem[i] = rb;
        end

        reset      = 1'b1;
        vid_req    = 1'b1;
        host_req   = 1'b1;
        host_we    = 1'b0;
        vid_addr   = '0;
        host_addr  = '0;
        host_wdata = '0;

        // Reset held three cycles with both requests asserted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_eq("rst_gnt", {vid_gnt, host_gnt, ram_en, ram_we}, 4'b0000);
            tick();
        end
        reset    = 1'b0;
        host_req = 1'b0;
        @(negedge clock);
        check_eq("post_rst_vgnt", vid_gnt, 1'b1);
        tick();

        // Host write then read of the same byte.
        vid_req    = 1'b0;
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 11'h005;
        host_wdata = 8'hF3;
        tick();
        host_we = 1'b0;
        @(negedge clock);
        check_eq("wr_no_rvalid", host_rvalid, 1'b0);
        tick();
        host_req = 1'b0;
        @(negedge clock);
        check_eq("raw_rvalid", host_rvalid, 1'b1);
        check_eq("raw_rdata",  host_rdata,  8'hF3);
        tick();

        // Video streaming reads 0..7.
        for (int i = 0; i < 8; i++) begin
            vid_req  = 1'b1;
            vid_addr = AW'(i);
            tick();
        end
        vid_req = 1'b0;
        tick();
        tick();

        // Starvation: video held, host read raised together.
        vid_req   = 1'b1;
        vid_addr  = AW'($urandom);
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = AW'($urandom);
        denied    = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (host_gnt) break;
            denied++;
            tick();
            vid_addr = AW'($urandom);
        end
        check_eq("starve_denied", denied, SMAX);
        check_eq("starve_vgnt", vid_gnt, 1'b0);
        tick();
        host_req = 1'b0;
        tick();
        vid_req = 1'b0;
        tick();

        // Alternating ownership.
        for (int i = 0; i < 6; i++) begin
            vid_req  = 1'b1;
            vid_addr = AW'($urandom);
            host_req = 1'b0;
            tick();
            vid_req   = 1'b0;
            host_req  = 1'b1;
            host_we   = 1'b0;
            host_addr = AW'($urandom);
            tick();
        end
        host_req = 1'b0;
        tick();

        // Host read granted, then reset in the following cycle.
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 11'h005;
        tick();
        host_req = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        check_eq("rst_drop_rvalid", host_rvalid, 1'b0);
        tick();
        reset = 1'b0;
        @(negedge clock);
        check_eq("rst_drop_after", host_rvalid, 1'b0);
        tick();

        // Randomized hold-until-grant traffic over a small address window.
        v_pend = 0;
        h_pend = 0;
        for (int i = 0; i < 3000; i++) begin
            if (v_pend && m_vg) v_pend = 0;
            if (h_pend && m_hg) h_pend = 0;
            if (!v_pend && $urandom_range(0, 3) != 0) begin
                v_pend   = 1;
                vid_addr = AW'($urandom_range(0, 15));
            end
            if (!h_pend && $urandom_range(0, 2) == 0) begin
                h_pend     = 1;
                host_we    = $urandom_range(0, 1) == 1;
                host_addr  = AW'($urandom_range(0, 15));
                host_wdata = DW'($urandom);
            end
            vid_req  = v_pend;
            host_req = h_pend;
            reset    = $urandom_range(0, 199) == 0;
            tick();
        end
        reset    = 1'b0;
        vid_req  = 1'b0;
        host_req = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one port of a RAMB16_S9_S9-class dual-port block RAM (2K x 8) between two requesters.
- Requester 1 is the video fetch path: read-only and latency-critical.
- Requester 2 is the host path: read/write.
- Video has fixed priority. A starvation counter guarantees the host a slot. The block sequences the BRAM enable, write-enable and address, and tags in-flight reads so returned data reaches the correct requester.

Parameters:
- ADDR_BITS, 11, BRAM address width.
- DATA_BITS, 8, BRAM data width.
- STARVE_MAX, 4, consecutive denied host cycles before the host is forced a grant (1..15).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- vid_req  in  1  video read request.
- vid_addr  in  ADDR_BITS  video read address.
- vid_gnt  out  1  video request accepted this cycle.
- vid_valid  out  1  vid_data holds read data for the access granted last cycle.
- vid_data  out  DATA_BITS  video read data (wired from ram_do).
- host_req  in  1  host request.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_BITS  host address.
- host_wdata  in  DATA_BITS  host write data.
- host_gnt  out  1  host request accepted this cycle.
- host_rvalid  out  1  host_rdata holds read data for the host read granted last cycle.
- host_rdata  out  DATA_BITS  host read data (wired from ram_do).
- ram_en  out  1  to BRAM EN.
- ram_we  out  1  to BRAM WE.
- ram_addr  out  ADDR_BITS  to BRAM ADDR.
- ram_di  out  DATA_BITS  to BRAM DI.
- ram_do  in  DATA_BITS  from BRAM DO (1-cycle registered read).

Behaviour:
- Handshake:
  - Requester holds req, addr, we and wdata stable until gnt is seen high at a rising edge.
  - gnt is combinational in the same cycle. It means the BRAM samples this access at the next edge.
  - Back-to-back grants to the same requester are allowed: one access per cycle, full throughput.
- Arbitration (combinational, evaluated each cycle):
  - Only vid_req high: video granted.
  - Only host_req high: host granted.
  - Both high: video granted, unless starve_cnt == STARVE_MAX, in which case the host is granted.
  - Neither high: no grant; ram_en=0, ram_we=0, ram_addr=0, ram_di=0.
- BRAM drive:
  - Granted video: ram_en=1, ram_we=0, ram_addr=vid_addr.
  - Granted host: ram_en=1, ram_we=host_we, ram_addr=host_addr, ram_di=host_wdata.
  - ram_di=0 whenever the host is not granted.
- starve_cnt (4 bits):
  - Clears when host_req is low or host_gnt is high.
  - Otherwise increments, saturating at STARVE_MAX.
- Return tag: a registered 2-bit tag (NONE/VID/HOST_RD) records the read granted this cycle.
  - vid_valid = (tag==VID).
  - host_rvalid = (tag==HOST_RD).
  - Host writes record NONE. No rvalid is produced for writes, even though BRAM WRITE_FIRST drives ram_do.
- Read latency: exactly 1 cycle from gnt to valid. vid_data and host_rdata equal ram_do and are meaningful only while the matching valid is high.
- Read-after-write, same address, consecutive cycles: the host read returns the newly written byte. This is inherent to BRAM ordering; no bypass logic.
- Reset:
  - During and after reset: tag=NONE, starve_cnt=0, vid_gnt=host_gnt=0, ram_en=0, ram_we=0.
  - Requests are ignored while reset is high.
  - Reset mid-operation discards the in-flight read: its valid is never asserted.

Decomposition:
- Shared package holds:
  - Default ADDR_BITS/DATA_BITS constants.
  - The 2-bit source-tag encoding: NONE=0, VID=1, HOST_RD=2.
- Flat module; no sub-module. The BRAM primitive is instantiated by the parent, which connects port B elsewhere.

Test Plan:
- Reset held 3 cycles with vid_req=host_req=1 -> all gnt/valid/ram_en/ram_we=0 throughout. Release reset -> vid_gnt=1 first cycle.
- Host write addr 11'h005 data 8'hF3 (vid idle), then host read 11'h005 -> write cycle: host_gnt=1, ram_we=1, no host_rvalid. Next cycle read granted; following cycle host_rvalid=1, host_rdata=8'hF3.
- Video streaming reads addrs 0..7 on consecutive cycles, host idle -> vid_gnt every cycle; vid_valid high cycles 1..8 with data matching preloaded bytes.
- vid_req held continuously, host_req read raised at cycle T -> host denied 4 cycles. host_gnt=1 at T+4; vid_gnt=0 that cycle; starve_cnt returns to 0.
- Video and host reads alternate ownership on adjacent cycles -> each valid pulses only for its own access; no cross-delivery of data.
- Host read granted, reset asserted the next cycle -> host_rvalid stays 0.
